beta_update_unit: RTL



---
 rtl/beta_update_unit_pkg.sv | 48 ++++
 rtl/beta_update_unit_lane.sv | 39 +++
 rtl/beta_update_unit.sv | 132 +++++++++++++
 3 files changed

// File: rtl/beta_update_unit_pkg.sv
// rtl/beta_update_unit_pkg.sv - shared widths, beat count and min-sum arithmetic
// Also used by the alpha-update unit; keep the function signatures stable.
package beta_update_unit_pkg;

  localparam int Q    = 6;
  localparam int P    = 16;
  localparam int MAXL = 10;
  localparam int SMAX = (1 << (Q - 1)) - 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  // Beats needed to stream a child of size 2^(l-1) through P lanes.
  function automatic logic [6:0] beat_count(input logic [4:0] l);
    if (l >= 5'd5) return 7'(1 << (l - 5'd5));
    return 7'd1;
  endfunction

  function automatic logic [P-1:0] lane_mask(input logic [4:0] l);
    logic [P-1:0] m;
    for (int i = 0; i < P; i++) m[i] = (l >= 5'd5) || (i < (1 << (int'(l) - 1)));
    return m;
  endfunction

  // The most negative code has no positive twin, so it is folded onto -SMAX.
  function automatic logic [Q-1:0] clamp_q(input logic [Q-1:0] a);
    if (a == {1'b1, {(Q-1){1'b0}}}) return Q'(-SMAX);
    return a;
  endfunction

  function automatic logic [Q-1:0] sat_add(input logic [Q-1:0] a, input logic [Q-1:0] b);
    int s;
    s = int'($signed(a)) + int'($signed(b));
    if (s > SMAX) return Q'(SMAX);
    if (s < -SMAX) return Q'(-SMAX);
    return Q'(s);
  endfunction

  function automatic logic [Q-1:0] f_minsum(input logic [Q-1:0] a, input logic [Q-1:0] b);
    int x, y, ax, ay, m;
    x  = int'($signed(a));
    y  = int'($signed(b));
    ax = (x < 0) ? -x : x;
    ay = (y < 0) ? -y : y;
    m  = (ax < ay) ? ax : ay;
    return ((x < 0) != (y < 0)) ? Q'(-m) : Q'(m);
  endfunction

endpackage

// File: rtl/beta_update_unit_lane.sv
// rtl/beta_update_unit_lane.sv - one registered SCAN beta-combine lane
// Output register clears whenever the beat is invalid or the lane is unused.
module beta_lane
  import beta_update_unit_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         valid,
  input  logic         active,
  input  logic [Q-1:0] bl,
  input  logic [Q-1:0] br,
  input  logic [Q-1:0] au,
  input  logic [Q-1:0] ad,
  output logic [Q-1:0] upper,
  output logic [Q-1:0] lower
);

  logic [Q-1:0] bl_c, br_c, au_c, ad_c, upper_d, lower_d;

  always_comb begin
    bl_c    = clamp_q(bl);
    br_c    = clamp_q(br);
    au_c    = clamp_q(au);
    ad_c    = clamp_q(ad);
    upper_d = f_minsum(bl_c, sat_add(br_c, ad_c));
    lower_d = sat_add(f_minsum(bl_c, au_c), br_c);
  end

  always_ff @(posedge clk) begin
    if (rst || !(valid && active)) begin
      upper <= '0;
      lower <= '0;
    end else begin
      upper <= upper_d;
      lower <= lower_d;
    end
  end

endmodule

// File: rtl/beta_update_unit.sv
// rtl/beta_update_unit.sv - P-lane beta-combine engine between beta storage read and write ports
// Reads one child beat per cycle; the write of beat k follows its read by two cycles.
module beta_update_unit
  import beta_update_unit_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [4:0]       layer,
  output logic             busy,
  output logic             done,
  output logic             rd_en,
  output logic [4:0]       rd_layer,
  output logic [5:0]       rd_cnt,
  input  logic [P*Q-1:0]   bl_in,
  input  logic [P*Q-1:0]   br_in,
  input  logic [P*Q-1:0]   au_in,
  input  logic [P*Q-1:0]   ad_in,
  output logic             wr_en,
  output logic [4:0]       wr_layer,
  output logic [5:0]       wr_cnt,
  output logic [2*P*Q-1:0] b_out
);

  state_t         state_q, state_d;
  logic [5:0]     cnt_q, cnt_d, last_q, last_d;
  logic [4:0]     lay_q, lay_d;
  logic [P-1:0]   mask_q, mask_d;
  logic           drain_q, drain_d;
  logic           v1_q, wr_en_q;
  logic [5:0]     c1_q, wr_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      last_q  <= '0;
      lay_q   <= '0;
      mask_q  <= '0;
      drain_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      lay_q   <= lay_d;
      mask_q  <= mask_d;
      drain_q <= drain_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    lay_d   = lay_q;
    mask_d  = mask_q;
    drain_d = drain_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (layer != 5'd0 && layer <= 5'(MAXL)) begin
            state_d = S_RUN;
            cnt_d   = '0;
            last_d  = 6'(beat_count(layer) - 7'd1);
            lay_d   = layer;
            mask_d  = lane_mask(layer);
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_RUN: begin
        if (cnt_q == last_q) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
          drain_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      S_DRAIN: begin
        drain_d = 1'b1;
        if (drain_q) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
        lay_d   = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rd_en    = (state_q == S_RUN);
  assign rd_cnt   = rd_en ? cnt_q : '0;
  assign busy     = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done     = (state_q == S_DONE);
  assign rd_layer = (lay_q == 5'd0) ? 5'd0 : lay_q - 5'd1;
  assign wr_layer = lay_q;
  assign wr_en    = wr_en_q;
  assign wr_cnt   = wr_cnt_q;

  // Stage 1 marks the cycle operands arrive; stage 2 lines up with the lane registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q     <= 1'b0;
      c1_q     <= '0;
      wr_en_q  <= 1'b0;
      wr_cnt_q <= '0;
    end else begin
      v1_q     <= rd_en;
      c1_q     <= rd_cnt;
      wr_en_q  <= v1_q;
      wr_cnt_q <= c1_q;
    end
  end

  for (genvar i = 0; i < P; i++) begin : g_lane
    beta_lane u_lane (
      .clk    (clk),
      .rst    (rst),
      .valid  (v1_q),
      .active (mask_q[i]),
      .bl     (bl_in[i*Q +: Q]),
      .br     (br_in[i*Q +: Q]),
      .au     (au_in[i*Q +: Q]),
      .ad     (ad_in[i*Q +: Q]),
      .upper  (b_out[i*Q +: Q]),
      .lower  (b_out[P*Q + i*Q +: Q])
    );
  end

endmodule
